game_flow_controller: RTL and testbench



---
 rtl/game_pkg.sv | 22 ++
 rtl/button_edge_sync.sv | 25 ++
 rtl/game_flow_controller.sv | 124 ++++++++++++
 tb/tb_game_flow_controller.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared types and defaults for the game flow controller.
package game_pkg;

  typedef enum logic [2:0] {
    TITLE      = 3'd0,
    ARM        = 3'd1,
    PLAY       = 3'd2,
    WIN_PAUSE  = 3'd3,
    LOSE_PAUSE = 3'd4,
    GAME_OVER  = 3'd5,
    VICTORY    = 3'd6
  } game_state_t;

  localparam int unsigned NUM_LEVELS_DEF   = 3;
  localparam int unsigned START_LIVES_DEF  = 3;
  localparam int unsigned PAUSE_CYCLES_DEF = 50_000_000;

  localparam int unsigned LIVES_W = 3;
  localparam int unsigned LEVEL_W = 2;
  localparam int unsigned STATE_W = 3;

endpackage

// File: rtl/button_edge_sync.sv
// Synchronises an active-low push button and emits one pulse per press.
module button_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic btn_n_i,
  output logic press_o
);

  // sync_q[1] is the synchronised level, sync_q[2] its previous value
  logic [2:0] sync_q;
  logic       press_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q  <= 3'b111;
      press_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[1:0], btn_n_i};
      press_q <= sync_q[2] & ~sync_q[1];
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/game_flow_controller.sv
// Top-level game sequencer: title, level play, banners, game over and victory.
module game_flow_controller
  import game_pkg::*;
#(
  parameter int unsigned NUM_LEVELS   = NUM_LEVELS_DEF,
  parameter int unsigned START_LIVES  = START_LIVES_DEF,
  parameter int unsigned PAUSE_CYCLES = PAUSE_CYCLES_DEF
) (
  input  logic               vga_clock,
  input  logic               reset,
  input  logic               start_button,
  input  logic               level_win,
  input  logic               level_lose,
  output logic               level_reset_n,
  output logic [LEVEL_W-1:0] level_index,
  output logic [LIVES_W-1:0] lives,
  output logic [STATE_W-1:0] game_state,
  output logic [LEVEL_W-1:0] levels_cleared
);

  localparam int unsigned CNT_W = $clog2(PAUSE_CYCLES) + 1;
  localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(PAUSE_CYCLES - 1);
  localparam logic [LEVEL_W-1:0] IDX_LAST  = LEVEL_W'(NUM_LEVELS - 1);
  localparam logic [LEVEL_W-1:0] CLR_ALL   = LEVEL_W'(NUM_LEVELS);
  localparam logic [LIVES_W-1:0] LIVES_RST = LIVES_W'(START_LIVES);

  game_state_t        state_q, state_d;
  logic [LIVES_W-1:0] lives_q, lives_d;
  logic [LEVEL_W-1:0] idx_q, idx_d;
  logic [LEVEL_W-1:0] clr_q, clr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               rstn_q, rstn_d;
  logic               start_pulse;

  button_edge_sync u_start_sync (
    .clk     (vga_clock),
    .rst     (reset),
    .btn_n_i (start_button),
    .press_o (start_pulse)
  );

  always_ff @(posedge vga_clock or posedge reset) begin
    if (reset) begin
      state_q <= TITLE;
      lives_q <= LIVES_RST;
      idx_q   <= '0;
      clr_q   <= '0;
      cnt_q   <= '0;
      rstn_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lives_q <= lives_d;
      idx_q   <= idx_d;
      clr_q   <= clr_d;
      cnt_q   <= cnt_d;
      rstn_q  <= rstn_d;
    end
  end

  always_comb begin
    state_d = state_q;
    lives_d = lives_q;
    idx_d   = idx_q;
    clr_d   = clr_q;
    cnt_d   = cnt_q;
    rstn_d  = 1'b0;

    case (state_q)
      TITLE: begin
        if (start_pulse) begin
          lives_d = LIVES_RST;
          clr_d   = '0;
          idx_d   = '0;
          state_d = ARM;
        end
      end
      // Level outputs are ignored here while the level settles after reset release
      ARM: state_d = PLAY;
      PLAY: begin
        if (level_lose) begin
          state_d = LOSE_PAUSE;
          cnt_d   = '0;
          if (lives_q != '0) lives_d = lives_q - LIVES_W'(1);
        end else if (level_win) begin
          state_d = WIN_PAUSE;
          cnt_d   = '0;
          clr_d   = clr_q + LEVEL_W'(1);
        end
      end
      WIN_PAUSE: begin
        if (cnt_q == CNT_LAST) begin
          if (clr_q == CLR_ALL) begin
            state_d = VICTORY;
          end else begin
            if (idx_q < IDX_LAST) idx_d = idx_q + LEVEL_W'(1);
            state_d = ARM;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      LOSE_PAUSE: begin
        if (cnt_q == CNT_LAST) begin
          state_d = (lives_q == '0) ? GAME_OVER : ARM;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      GAME_OVER, VICTORY: begin
        if (start_pulse) state_d = TITLE;
      end
      default: state_d = TITLE;
    endcase

    rstn_d = (state_d == ARM) || (state_d == PLAY);
  end

  assign level_reset_n  = rstn_q;
  assign level_index    = idx_q;
  assign lives          = lives_q;
  assign game_state     = state_q;
  assign levels_cleared = clr_q;

endmodule

// File: tb/tb_game_flow_controller.sv
// Bench for game_flow_controller: directed vector table plus randomized games
// checked against an episode-level model of the game rules.
module tb_game_flow_controller;
  import game_pkg::*;

  localparam int PAUSE = 4;
  localparam int NLVL  = 3;
  localparam int LIVES0 = 3;

  logic       clk = 1'b0;
  logic       reset, start_button, level_win, level_lose;
  logic       level_reset_n;
  logic [1:0] level_index;
  logic [2:0] lives;
  logic [2:0] game_state;
  logic [1:0] levels_cleared;

  int n_cmp = 0;
  int n_err = 0;

  // Model of the game: only the quantities the player sees
  int m_lives, m_idx, m_clr;

  game_flow_controller #(.NUM_LEVELS(NLVL), .START_LIVES(LIVES0), .PAUSE_CYCLES(PAUSE)) dut (
    .vga_clock      (clk),
    .reset          (reset),
    .start_button   (start_button),
    .level_win      (level_win),
    .level_lose     (level_lose),
    .level_reset_n  (level_reset_n),
    .level_index    (level_index),
    .lives          (lives),
    .game_state     (game_state),
    .levels_cleared (levels_cleared)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        win;
    logic        lose;
    game_state_t st;
    int          lv;
    int          idx;
    int          clr;
    logic        rstn;
  } vec_t;

  vec_t tbl[25];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input game_state_t st, input int lv, input int idx,
                         input int clr, input int rstn);
    chk({tag, ".state"}, int'(game_state), int'(st));
    chk({tag, ".lives"}, int'(lives), lv);
    chk({tag, ".index"}, int'(level_index), idx);
    chk({tag, ".cleared"}, int'(levels_cleared), clr);
    chk({tag, ".rstn"}, int'(level_reset_n), rstn);
  endtask

  // Hold the button low until the state becomes tgt (bounded)
  task automatic press_until(input string tag, input game_state_t tgt);
    bit seen = 0;
    start_button = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      step();
      if (game_state == 3'(tgt)) seen = 1;
    end
    chk({tag, ".reached"}, int'(seen), 1);
  endtask

  task automatic start_game(input string tag, input int hold);
    press_until(tag, ARM);
    m_lives = LIVES0; m_idx = 0; m_clr = 0;
    chk_all({tag, ".arm"}, ARM, m_lives, 0, 0, 1);
    step();
    chk_all({tag, ".play"}, PLAY, m_lives, 0, 0, 1);
    for (int i = 0; i < hold; i++) step();
    if (hold > 0) chk({tag, ".held"}, int'(game_state), int'(PLAY));
    start_button = 1'b1;
  endtask

  task automatic to_title(input string tag);
    if (game_state != 3'(TITLE)) begin
      press_until(tag, TITLE);
      for (int i = 0; i < 10; i++) step();
      chk({tag, ".stay"}, int'(game_state), int'(TITLE));
      start_button = 1'b1;
      repeat (4) step();
    end
  endtask

  // One level attempt from PLAY; returns 1 when the game has ended
  task automatic episode(input string tag, input bit w, input bit l, output bit done);
    game_state_t pst, fst;
    done = 0;
    if (l) begin
      pst = LOSE_PAUSE;
      m_lives = (m_lives > 0) ? m_lives - 1 : 0;
      fst = (m_lives == 0) ? GAME_OVER : ARM;
    end else begin
      pst = WIN_PAUSE;
      m_clr++;
      fst = (m_clr == NLVL) ? VICTORY : ARM;
    end
    level_win = w; level_lose = l;
    step();
    level_win = 0; level_lose = 0;
    chk_all({tag, ".pause0"}, pst, m_lives, m_idx, m_clr, 0);
    for (int i = 1; i < PAUSE; i++) begin
      step();
      chk({tag, ".pause"}, int'(game_state), int'(pst));
      chk({tag, ".pause_rstn"}, int'(level_reset_n), 0);
    end
    if (!l && fst == ARM) m_idx++;
    step();
    chk_all({tag, ".after"}, fst, m_lives, m_idx, m_clr, (fst == ARM) ? 1 : 0);
    if (fst == ARM) begin
      step();
      chk({tag, ".replay"}, int'(game_state), int'(PLAY));
    end else begin
      done = 1;
    end
  endtask

  initial begin
    bit done;
    reset = 1'b1; start_button = 1'b1; level_win = 1'b0; level_lose = 1'b0;
    tbl[0]  = '{1, 0, WIN_PAUSE,  3, 0, 1, 0};
    tbl[1]  = '{0, 0, WIN_PAUSE,  3, 0, 1, 0};
    tbl[2]  = '{0, 0, WIN_PAUSE,  3, 0, 1, 0};
    tbl[3]  = '{0, 0, WIN_PAUSE,  3, 0, 1, 0};
    tbl[4]  = '{0, 0, ARM,        3, 1, 1, 1};
    tbl[5]  = '{1, 0, PLAY,       3, 1, 1, 1};
    tbl[6]  = '{0, 0, PLAY,       3, 1, 1, 1};
    tbl[7]  = '{1, 1, LOSE_PAUSE, 2, 1, 1, 0};
    tbl[8]  = '{0, 0, LOSE_PAUSE, 2, 1, 1, 0};
    tbl[9]  = '{0, 0, LOSE_PAUSE, 2, 1, 1, 0};
    tbl[10] = '{0, 0, LOSE_PAUSE, 2, 1, 1, 0};
    tbl[11] = '{0, 0, ARM,        2, 1, 1, 1};
    tbl[12] = '{0, 0, PLAY,       2, 1, 1, 1};
    tbl[13] = '{1, 0, WIN_PAUSE,  2, 1, 2, 0};
    tbl[14] = '{0, 0, WIN_PAUSE,  2, 1, 2, 0};
    tbl[15] = '{0, 0, WIN_PAUSE,  2, 1, 2, 0};
    tbl[16] = '{0, 0, WIN_PAUSE,  2, 1, 2, 0};
    tbl[17] = '{0, 0, ARM,        2, 2, 2, 1};
    tbl[18] = '{0, 0, PLAY,       2, 2, 2, 1};
    tbl[19] = '{1, 0, WIN_PAUSE,  2, 2, 3, 0};
    tbl[20] = '{0, 0, WIN_PAUSE,  2, 2, 3, 0};
    tbl[21] = '{0, 0, WIN_PAUSE,  2, 2, 3, 0};
    tbl[22] = '{0, 0, WIN_PAUSE,  2, 2, 3, 0};
    tbl[23] = '{0, 0, VICTORY,    2, 2, 3, 0};
    tbl[24] = '{1, 0, VICTORY,    2, 2, 3, 0};

    step(); step();
    chk_all("reset", TITLE, LIVES0, 0, 0, 0);
    reset = 1'b0;
    step();
    chk_all("idle", TITLE, LIVES0, 0, 0, 0);

    start_game("start", 10);

    for (int i = 0; i < 25; i++) begin
      level_win = tbl[i].win; level_lose = tbl[i].lose;
      step();
      chk_all($sformatf("vec%0d", i), tbl[i].st, tbl[i].lv, tbl[i].idx, tbl[i].clr, int'(tbl[i].rstn));
    end
    level_win = 0; level_lose = 0;

    // Victory back to title leaves the scoreboard untouched
    to_title("victory_exit");
    chk_all("title_after_win", TITLE, 2, 2, 3, 0);

    start_game("go_start", 0);
    for (int k = 0; k < LIVES0; k++) episode($sformatf("go_lose%0d", k), 0, 1, done);
    chk_all("game_over", GAME_OVER, 0, 0, 0, 0);
    to_title("go_exit");
    start_game("restart", 0);

    for (int g = 0; g < 20; g++) begin
      done = 0;
      for (int e = 0; e < 10 && !done; e++) begin
        int idle = $urandom_range(0, 3);
        int r = $urandom_range(0, 2);
        for (int c = 0; c < idle; c++) begin
          start_button = 1'($urandom_range(0, 1));
          step();
          chk("rnd.idle", int'(game_state), int'(PLAY));
        end
        start_button = 1'b1;
        episode($sformatf("rnd%0d_%0d", g, e), (r != 1), (r != 0), done);
      end
      chk("rnd.ended", int'(done), 1);
      to_title($sformatf("rnd%0d_exit", g));
      start_game($sformatf("rnd%0d_next", g), 0);
    end

    // Reset in the middle of a banner must act before the next edge
    level_lose = 1'b1;
    step();
    level_lose = 1'b0;
    step(); step();
    chk("mid.pause", int'(game_state), int'(LOSE_PAUSE));
    #2 reset = 1'b1;
    #1;
    chk_all("mid_reset", TITLE, LIVES0, 0, 0, 0);
    step();
    reset = 1'b0;
    step();
    chk_all("post_reset", TITLE, LIVES0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
